// File: rtl/psum_drain_fifo.sv
// Rebuilds valid/last for the psum stream leaving the bottom PE of a systolic column
// by delaying the issue strobe, and buffers captured psums in a small FWFT FIFO.
module psum_drain_fifo #(
  parameter int DATA_W   = 16,
  parameter int PSUM_LAT = 36,
  parameter int DEPTH    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_issue_valid,
  input  logic                     i_issue_last,
  input  logic [DATA_W-1:0]        i_psum_in,
  output logic [DATA_W-1:0]        o_out_data,
  output logic                     o_out_valid,
  output logic                     o_out_last,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PSUM_LAT-1:0] r_dly_v;
  logic [PSUM_LAT-1:0] r_dly_l;
  logic [DATA_W:0]     r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;

  logic                w_cap_v;
  logic                w_cap_l;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;
  logic [DATA_W:0]     w_head;

  // The PE chain has no valid, so the issue strobe is replayed PSUM_LAT cycles later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dly_v <= '0;
      r_dly_l <= '0;
    end else begin
      r_dly_v[0] <= i_issue_valid;
      r_dly_l[0] <= i_issue_valid & i_issue_last;
      for (int i = 1; i < PSUM_LAT; i++) begin
        r_dly_v[i] <= r_dly_v[i-1];
        r_dly_l[i] <= r_dly_l[i-1];
      end
    end
  end

  assign w_cap_v = r_dly_v[PSUM_LAT-1];
  assign w_cap_l = r_dly_l[PSUM_LAT-1];

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = o_out_valid && i_out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_wr   = w_cap_v && (!w_full || w_pop);
  assign w_drop = w_cap_v && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr) begin
      r_mem[r_wr_ptr] <= {w_cap_l, i_psum_in};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A fresh drop outranks a simultaneous clear so no loss goes unreported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_out_valid = (r_count != '0);
  assign o_out_data  = o_out_valid ? w_head[DATA_W-1:0] : '0;
  assign o_out_last  = o_out_valid ? w_head[DATA_W] : 1'b0;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;

endmodule

// File: doc/psum_drain_fifo.md
Name: psum_drain_fifo

Overview:
- Sits directly downstream of the bottom PE of one systolic-array column; consumes the FP16 psum_out stream that the column produces.
- The PE chain carries no valid signal. This block rebuilds valid and last-of-tile flags by delaying the column issue strobe by the fixed pipeline latency.
- Captured psums go into a small first-word-fall-through FIFO with a valid/ready output toward the writeback stage.
- Overflow is detected and flagged.

Parameters:
- DATA_W, 16: psum width, FP16 bit pattern, passed through untouched.
- PSUM_LAT, 36: cycles from issue_valid at the column top to the matching psum at psum_in (9-cycle MAC × 4 rows). Must be ≥1.
- DEPTH, 8: FIFO entries. Must be a power of two and ≥2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  an ifmap element entered the column top this cycle.
- issue_last  in  1  qualifies issue_valid: last element of the tile.
- psum_in  in  DATA_W  psum_out of the bottom PE.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_last  out  1  last flag of the head entry.
- out_ready  in  1  consumer accepts the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a capture was dropped.
- clear_ovf  in  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset state:
  - Delay line cleared.
  - Read and write pointers at 0; count = 0; overflow = 0.
  - out_valid = 0; out_last = 0; out_data = 0 (memory contents are don't-care, output gated to 0 when empty).
  - Issues in flight when reset asserts are discarded. Reset mid-stream gives no spurious capture after release.
- Delay line:
  - PSUM_LAT-stage shift register of {issue_valid, issue_last}; issue_last is ANDed with issue_valid on entry.
  - cap_v and cap_l are the tap at stage PSUM_LAT.
  - issue_valid at cycle t gives cap_v = 1 in cycle t+PSUM_LAT. psum_in is sampled at the end of that cycle.
  - Back-to-back issues give back-to-back captures, one per cycle, order preserved.
- Write: cap_v = 1 and (count < DEPTH or pop this cycle) → mem[wr_ptr] = {cap_l, psum_in}; wr_ptr increments modulo DEPTH.
- Read (pop): out_valid && out_ready → rd_ptr increments modulo DEPTH.
- Output is first-word-fall-through:
  - out_valid = (count != 0).
  - out_data and out_last come from mem[rd_ptr], combinationally from registered state.
  - A word captured at the end of cycle t+PSUM_LAT is visible from cycle t+PSUM_LAT+1.
- count update:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop, or on neither.
- Boundary conditions:
  - Full with pop and cap_v in the same cycle: write accepted, count stays at DEPTH, no overflow.
  - Full with cap_v and no pop: the psum is dropped, overflow is set to 1, count and pointers unchanged.
  - Empty with cap_v: out_ready is ignored that cycle (out_valid = 0). The word appears next cycle.
  - out_ready while empty: no effect.
- overflow is cleared by clear_ovf. If clear_ovf and a new drop occur in the same cycle, set wins.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and roll over from DEPTH−1 to 0. Full and empty are distinguished only by count.
- psum_in is never inspected, so FP16 NaN, Inf and denormal patterns pass bit-exact.

Test Plan:
- Reset, then one issue_valid pulse at cycle 10 with psum_in = 16'h3C00 driven at cycle 46 → out_valid rises at cycle 47, out_data = 16'h3C00, out_last = 0, count = 1. With out_ready = 1 at cycle 47, count = 0 at cycle 48.
- Four consecutive issues (the last with issue_last = 1), psum_in = 16'h4000, 4200, 4400, 4500 at capture cycles, out_ready held 1 → four words out in order on consecutive cycles; out_last = 1 only on 16'h4500.
- out_ready = 0, ten consecutive captures of values 1..10 → count saturates at 8, overflow = 1, and the FIFO holds 1..8. Then out_ready = 1 → exactly 1..8 are drained. clear_ovf → overflow = 0.
- Full FIFO, out_ready = 1 and cap_v in the same cycle → count stays 8, overflow stays 0, the new value appears after the 7 older entries; wrap-around verified over 20+ pushes with a scoreboard.
- issue_valid every cycle, then rst asserted for 1 cycle at cycle 20 → at the rst edge count = 0, out_valid = 0, overflow = 0. No captures from pre-reset issues ever appear; post-reset issues capture normally.
- Simultaneous overflow drop and clear_ovf → overflow remains 1 the next cycle.
